// File: rtl/db_pkg.sv
// Shared constants and counter sizing for the debouncer bank.
// Defaults assume a 50 MHz system clock.
package db_pkg;

  localparam int DB_STABLE_50MHZ_10MS = 500000;
  localparam int DB_LONG_50MHZ_1S     = 50000000;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int db_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/db_bank_if.sv
// Pin-side and event-side signals of the debouncer bank, one bit per channel.
// No handshake: button is sampled every clock; level/toggle are levels and
// rise/fall/long_press are single-cycle pulses, all registered.
interface db_bank_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] button;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] long_press;

  modport master (
    output button,
    input  level, rise, fall, toggle, long_press
  );

  modport slave (
    input  button,
    output level, rise, fall, toggle, long_press
  );

endinterface

// File: rtl/db_channel.sv
// One debouncer channel: two-flop synchroniser, stability filter,
// optional toggle latch and long-press hold counter.
module db_channel
  import db_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_50MHZ_10MS,
  parameter int LONG_CYCLES   = DB_LONG_50MHZ_1S,
  parameter bit INVERT        = 1'b0,
  parameter bit TOGGLE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle,
  output logic long_press
);

  localparam int CW = db_width(STABLE_CYCLES);
  localparam int HW = db_width(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam bit LONG_EN = (LONG_CYCLES > 0);

  logic          pin;
  logic          sync1;
  logic          sync2;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;
  logic          upd;

  // Inversion happens before the synchroniser so the filter only sees active-high.
  assign pin   = button ^ INVERT;
  assign level = lvl;

  always_comb begin
    upd = (sync2 != lvl) && (cnt == CNT_MAX);
  end

  always_comb begin
    hcnt_nxt = '0;
    if (lvl) begin
      if (hcnt == HOLD_MAX) hcnt_nxt = hcnt;
      else                  hcnt_nxt = hcnt + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Any sample agreeing with the stable level restarts the count.
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (upd) begin
        cnt <= '0;
        lvl <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      rise <= upd & sync2;
      fall <= upd & ~sync2;
      if (TOGGLE_EN && upd && sync2) toggle <= ~toggle;
    end
  end

  // Saturating hold counter; the pulse marks the single cycle it reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      hcnt       <= hcnt_nxt;
      long_press <= LONG_EN && lvl && (hcnt != HOLD_MAX) && (hcnt_nxt == HOLD_MAX);
    end
  end

endmodule

// File: rtl/db_bank.sv
// Bank of N_CH independent debouncers sharing one clock and reset.
// Per-channel polarity and toggle enable come from the mask parameters.
module db_bank
  import db_pkg::*;
#(
  parameter int              N_CH          = 4,
  parameter int              STABLE_CYCLES = DB_STABLE_50MHZ_10MS,
  parameter int              LONG_CYCLES   = DB_LONG_50MHZ_1S,
  parameter logic [N_CH-1:0] INVERT_MASK   = {N_CH{1'b0}},
  parameter logic [N_CH-1:0] TOGGLE_MASK   = {N_CH{1'b0}}
) (
  input logic       clk,
  input logic       rst,
  db_bank_if.slave  bus
);

  logic [N_CH-1:0] level_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] fall_w;
  logic [N_CH-1:0] toggle_w;
  logic [N_CH-1:0] long_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .INVERT        (INVERT_MASK[i]),
      .TOGGLE_EN     (TOGGLE_MASK[i])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .button     (bus.button[i]),
      .level      (level_w[i]),
      .rise       (rise_w[i]),
      .fall       (fall_w[i]),
      .toggle     (toggle_w[i]),
      .long_press (long_w[i])
    );
  end

  assign bus.level      = level_w;
  assign bus.rise       = rise_w;
  assign bus.fall       = fall_w;
  assign bus.toggle     = toggle_w;
  assign bus.long_press = long_w;

endmodule
